// File: rtl/ivs_timing_gen.sv
// Video timing generator: h/v counters over shadowed porch/sync/active config,
// registered DE/HS/VS/coordinates and frame pulses aligned one cycle behind the counters.
module ivs_timing_gen #(
    parameter int CNT_W = 12
) (
    input  logic             hclk,
    input  logic             hrst_n,
    input  logic             sw_rst,
    input  logic [31:0]      glb_ctrl,
    input  logic [31:0]      cfg_par0,
    input  logic [31:0]      cfg_par1,
    input  logic [31:0]      cfg_par2,
    input  logic [31:0]      cfg_par3,
    output logic             vid_de,
    output logic             vid_hs,
    output logic             vid_vs,
    output logic [CNT_W-1:0] vid_x,
    output logic [CNT_W-1:0] vid_y,
    output logic             frame_start,
    output logic             frame_done,
    output logic             busy,
    output logic             cfg_err,
    output logic [15:0]      frame_cnt
);
    localparam int TW = CNT_W + 2;

    typedef enum logic {IDLE, RUN} state_t;

    state_t           state, state_nxt;
    logic [TW-1:0]    h_cnt, v_cnt, h_nxt, v_nxt;
    logic             armed, armed_nxt, err_nxt, load_sh;

    logic [CNT_W-1:0] sh_ha, sh_hfp, sh_hs, sh_hbp, sh_va, sh_vfp, sh_vs, sh_vbp;
    logic [CNT_W-1:0] lv_ha, lv_hfp, lv_hs, lv_hbp, lv_va, lv_vfp, lv_vs, lv_vbp;
    logic [TW-1:0]    htotal, vtotal, hs_lo, hs_hi, vs_lo, vs_hi;
    logic             en, single, live_ok, h_last, f_last, run;

    logic             de_r, hs_act_r, vs_act_r, fs_r, fd_r, busy_r;
    logic [CNT_W-1:0] x_r, y_r;
    logic [15:0]      fcnt_r;
    logic             unused_bits;

    assign unused_bits = ^{glb_ctrl, cfg_par0, cfg_par1, cfg_par2, cfg_par3};

    assign lv_ha  = cfg_par0[CNT_W-1:0];
    assign lv_va  = cfg_par0[16 +: CNT_W];
    assign lv_hfp = cfg_par1[CNT_W-1:0];
    assign lv_hs  = cfg_par1[16 +: CNT_W];
    assign lv_hbp = cfg_par2[CNT_W-1:0];
    assign lv_vfp = cfg_par2[16 +: CNT_W];
    assign lv_vs  = cfg_par3[CNT_W-1:0];
    assign lv_vbp = cfg_par3[16 +: CNT_W];

    assign en      = glb_ctrl[0];
    assign single  = glb_ctrl[3];
    assign live_ok = (lv_ha != '0) && (lv_va != '0);

    assign hs_lo  = TW'(sh_ha) + TW'(sh_hfp);
    assign hs_hi  = hs_lo + TW'(sh_hs);
    assign htotal = hs_hi + TW'(sh_hbp);
    assign vs_lo  = TW'(sh_va) + TW'(sh_vfp);
    assign vs_hi  = vs_lo + TW'(sh_vs);
    assign vtotal = vs_hi + TW'(sh_vbp);

    assign h_last = (h_cnt == htotal - 1'b1);
    assign f_last = h_last && (v_cnt == vtotal - 1'b1);
    assign run    = (state == RUN);

    always_comb begin
        state_nxt = state;
        h_nxt     = h_cnt;
        v_nxt     = v_cnt;
        armed_nxt = armed;
        err_nxt   = cfg_err;
        load_sh   = 1'b0;
        case (state)
            IDLE: begin
                if (en && armed) begin
                    if (live_ok) begin
                        state_nxt = RUN;
                        h_nxt     = '0;
                        v_nxt     = '0;
                        load_sh   = 1'b1;
                        err_nxt   = 1'b0;
                    end else begin
                        err_nxt = 1'b1;
                    end
                end
            end
            RUN: begin
                if (f_last) begin
                    h_nxt = '0;
                    v_nxt = '0;
                    if (en && !single && live_ok) load_sh = 1'b1;
                    else state_nxt = IDLE;
                    if (single) armed_nxt = 1'b0;
                end else if (h_last) begin
                    h_nxt = '0;
                    v_nxt = v_cnt + 1'b1;
                end else begin
                    h_nxt = h_cnt + 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
        if (!en) armed_nxt = 1'b1;
    end

    // Counter stage: position of the cycle whose outputs are registered next.
    always_ff @(posedge hclk or negedge hrst_n) begin
        if (!hrst_n) begin
            state   <= IDLE;
            h_cnt   <= '0;
            v_cnt   <= '0;
            armed   <= 1'b1;
            cfg_err <= 1'b0;
        end else if (sw_rst) begin
            state   <= IDLE;
            h_cnt   <= '0;
            v_cnt   <= '0;
            armed   <= 1'b1;
            cfg_err <= 1'b0;
        end else begin
            state   <= state_nxt;
            h_cnt   <= h_nxt;
            v_cnt   <= v_nxt;
            armed   <= armed_nxt;
            cfg_err <= err_nxt;
        end
    end

    always_ff @(posedge hclk or negedge hrst_n) begin
        if (!hrst_n) begin
            sh_ha <= '0; sh_hfp <= '0; sh_hs <= '0; sh_hbp <= '0;
            sh_va <= '0; sh_vfp <= '0; sh_vs <= '0; sh_vbp <= '0;
        end else if (load_sh && !sw_rst) begin
            sh_ha <= lv_ha; sh_hfp <= lv_hfp; sh_hs <= lv_hs; sh_hbp <= lv_hbp;
            sh_va <= lv_va; sh_vfp <= lv_vfp; sh_vs <= lv_vs; sh_vbp <= lv_vbp;
        end
    end

    // Output stage: everything decoded from the counter stage, registered together.
    always_ff @(posedge hclk or negedge hrst_n) begin
        if (!hrst_n) begin
            de_r <= 1'b0; hs_act_r <= 1'b0; vs_act_r <= 1'b0;
            fs_r <= 1'b0; fd_r <= 1'b0; busy_r <= 1'b0;
            x_r  <= '0;   y_r  <= '0;   fcnt_r <= '0;
        end else if (sw_rst) begin
            de_r <= 1'b0; hs_act_r <= 1'b0; vs_act_r <= 1'b0;
            fs_r <= 1'b0; fd_r <= 1'b0; busy_r <= 1'b0;
            x_r  <= '0;   y_r  <= '0;   fcnt_r <= '0;
        end else begin
            busy_r   <= run;
            de_r     <= run && (h_cnt < TW'(sh_ha)) && (v_cnt < TW'(sh_va));
            hs_act_r <= run && (h_cnt >= hs_lo) && (h_cnt < hs_hi);
            vs_act_r <= run && (v_cnt >= vs_lo) && (v_cnt < vs_hi);
            fs_r     <= run && (h_cnt == '0) && (v_cnt == '0);
            fd_r     <= run && f_last;
            x_r      <= run ? h_cnt[CNT_W-1:0] : '0;
            y_r      <= run ? v_cnt[CNT_W-1:0] : '0;
            if (fd_r) fcnt_r <= fcnt_r + 16'd1;
        end
    end

    // Polarity is live, so the idle level follows the control bits even in reset.
    assign vid_hs      = hs_act_r ^ glb_ctrl[1];
    assign vid_vs      = vs_act_r ^ glb_ctrl[2];
    assign vid_de      = de_r;
    assign vid_x       = x_r;
    assign vid_y       = y_r;
    assign frame_start = fs_r;
    assign frame_done  = fd_r;
    assign busy        = busy_r;
    assign frame_cnt   = fcnt_r;
endmodule

// File: tb/tb_ivs_timing_gen.sv
// Directed bench for ivs_timing_gen: config table of single-shot frames plus
// hand-written sequences for continuous, re-arm, soft/async reset and config error.
module tb_ivs_timing_gen;
    logic        hclk = 0, hrst_n = 0, sw_rst = 0;
    logic [31:0] glb_ctrl = 0, cfg_par0 = 0, cfg_par1 = 0, cfg_par2 = 0, cfg_par3 = 0;
    logic        vid_de, vid_hs, vid_vs, frame_start, frame_done, busy, cfg_err;
    logic [11:0] vid_x, vid_y;
    logic [15:0] frame_cnt;
    int n_pass = 0, n_total = 0;

    ivs_timing_gen #(.CNT_W(12)) dut (
        .hclk(hclk), .hrst_n(hrst_n), .sw_rst(sw_rst), .glb_ctrl(glb_ctrl),
        .cfg_par0(cfg_par0), .cfg_par1(cfg_par1), .cfg_par2(cfg_par2), .cfg_par3(cfg_par3),
        .vid_de(vid_de), .vid_hs(vid_hs), .vid_vs(vid_vs), .vid_x(vid_x), .vid_y(vid_y),
        .frame_start(frame_start), .frame_done(frame_done), .busy(busy),
        .cfg_err(cfg_err), .frame_cnt(frame_cnt)
    );

    always #5 hclk = ~hclk;

    typedef struct {
        logic [15:0] ha, hfp, hs, hbp, va, vfp, vs, vbp;
        logic        hpol, vpol;
        int          len, de_n, hs_n, vs_n;
    } vec_t;
    vec_t vt[5];

    task automatic tick();
        @(posedge hclk); #1;
    endtask

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic set_cfg(input logic [15:0] ha, hfp, hs, hbp, va, vfp, vs, vbp);
        cfg_par0 = {va, ha};
        cfg_par1 = {hs, hfp};
        cfg_par2 = {vfp, hbp};
        cfg_par3 = {vbp, vs};
    endtask

    task automatic wait_fs();
        int c = 0;
        while (!frame_start && c < 50) begin tick(); c++; end
        check("start_seen", frame_start, 1);
    endtask

    // Called on a frame_start cycle; returns on the frame_done cycle.
    task automatic run_frame(input int act_at, input int which, input logic [31:0] val,
                             output int len, output int de_n);
        bit done = 0;
        len = 0; de_n = 0;
        for (int c = 0; c < 500; c++) begin
            if (c == act_at) begin
                if (which == 1) cfg_par0 = val;
                else if (which == 2) glb_ctrl = val;
            end
            len++;
            de_n += int'(vid_de);
            if (frame_done) begin done = 1; break; end
            tick();
        end
        check("frame_done_seen", done, 1);
    endtask

    task automatic sw_reset();
        sw_rst = 1; tick(); sw_rst = 0;
    endtask

    initial begin
        int len, de_n, hs_n, vs_n, fd_n;
        logic [29:0] exp_v;
        bit seen;

        vt[0] = '{4,1,2,1, 3,1,1,1, 0,0, 48, 12, 12,  8};
        vt[1] = '{3,0,1,0, 2,0,1,0, 0,0, 12,  6,  3,  4};
        vt[2] = '{2,1,0,1, 2,1,0,1, 0,0, 16,  4,  0,  0};
        vt[3] = '{5,2,3,2, 1,0,2,1, 1,1, 48,  5, 12, 24};
        vt[4] = '{1,0,0,0, 1,0,0,0, 0,0,  1,  1,  0,  0};

        set_cfg(4,1,2,1, 3,1,1,1);
        #12;
        check("rst_outputs", {busy, vid_de, vid_hs, vid_vs, frame_start, frame_done, cfg_err, vid_x, vid_y, frame_cnt}, 0);
        hrst_n = 1;
        tick();

        // Basic single-shot frame, checked cycle by cycle
        glb_ctrl = 32'h9;
        tick();
        check("start_latency_busy", busy, 0);
        tick();
        for (int i = 0; i < 48; i++) begin
            exp_v = {1'b1, (i % 8 < 4) && (i / 8 < 3), (i % 8 == 5) || (i % 8 == 6), i / 8 == 4,
                     i == 0, i == 47, 12'(i % 8), 12'(i / 8)};
            check($sformatf("basic_cyc%0d", i),
                  {busy, vid_de, vid_hs, vid_vs, frame_start, frame_done, vid_x, vid_y}, exp_v);
            tick();
        end
        check("basic_idle_after", {busy, frame_cnt}, {1'b0, 16'd1});

        // Single-shot holds off while enable stays high, re-arms after a drop
        seen = 0;
        for (int i = 0; i < 6; i++) begin seen |= busy; tick(); end
        check("single_no_restart", seen, 0);
        glb_ctrl = 32'h8; tick();
        glb_ctrl = 32'h9;
        wait_fs();
        run_frame(-1, 0, 0, len, de_n);
        tick();
        check("rearm_frame_cnt", {busy, frame_cnt}, {1'b0, 16'd2});

        // Configuration table, one single-shot frame each
        for (int k = 0; k < 5; k++) begin
            glb_ctrl = 0;
            sw_rst = 1;
            set_cfg(vt[k].ha, vt[k].hfp, vt[k].hs, vt[k].hbp, vt[k].va, vt[k].vfp, vt[k].vs, vt[k].vbp);
            tick();
            sw_rst = 0;
            glb_ctrl = {28'd0, 1'b1, vt[k].vpol, vt[k].hpol, 1'b1};
            wait_fs();
            len = 0; de_n = 0; hs_n = 0; vs_n = 0; fd_n = 0;
            for (int c = 0; c < 400 && busy; c++) begin
                len++;
                de_n += int'(vid_de);
                hs_n += int'(vid_hs != vt[k].hpol);
                vs_n += int'(vid_vs != vt[k].vpol);
                fd_n += int'(frame_done);
                tick();
            end
            check($sformatf("vec%0d_len", k), len, vt[k].len);
            check($sformatf("vec%0d_de", k), de_n, vt[k].de_n);
            check($sformatf("vec%0d_hs", k), hs_n, vt[k].hs_n);
            check($sformatf("vec%0d_vs", k), vs_n, vt[k].vs_n);
            check($sformatf("vec%0d_done_cnt", k), {fd_n[7:0], frame_cnt}, {8'd1, 16'd1});
        end

        // Continuous: shadowed ha change, gapless frames, enable drop finishes frame
        glb_ctrl = 0;
        set_cfg(4,1,2,1, 3,1,1,1);
        sw_reset();
        glb_ctrl = 32'h1;
        wait_fs();
        run_frame(10, 1, {16'd3, 16'd6}, len, de_n);
        check("cont_f1_len", len, 48);
        check("cont_f1_de", de_n, 12);
        tick();
        check("cont_no_gap", frame_start, 1);
        run_frame(20, 2, 32'h0, len, de_n);
        check("cont_f2_len", len, 60);
        check("cont_f2_de", de_n, 18);
        tick();
        check("cont_stop", {busy, frame_start}, 0);

        // Soft reset mid-frame
        set_cfg(4,1,2,1, 3,1,1,1);
        glb_ctrl = 32'h1;
        wait_fs();
        run_frame(-1, 0, 0, len, de_n);
        tick();
        for (int i = 0; i < 10; i++) tick();
        check("swr_pos", {vid_x, vid_y, frame_cnt != 0}, {12'd2, 12'd1, 1'b1});
        sw_rst = 1;
        tick();
        check("swr_outputs", {busy, vid_de, vid_hs, vid_vs, frame_start, vid_x, vid_y, frame_cnt}, 0);
        sw_rst = 0;
        tick();
        check("swr_restart_lat", busy, 0);
        tick();
        check("swr_restart", {frame_start, busy}, 2'b11);

        // Config error, then fixed with active-low hsync
        glb_ctrl = 0;
        set_cfg(4,1,2,1, 0,1,1,1);
        sw_reset();
        glb_ctrl = 32'h1;
        tick(); tick(); tick();
        check("cfgerr_set", {cfg_err, busy}, 2'b10);
        set_cfg(4,1,2,1, 3,1,1,1);
        glb_ctrl = 32'hB;
        #1;
        check("hs_idle_low_pol", vid_hs, 1);
        tick();
        check("cfgerr_clear", cfg_err, 0);
        wait_fs();
        hs_n = 0;
        for (int c = 0; c < 200 && busy; c++) begin hs_n += int'(vid_hs == 0); tick(); end
        check("hs_low_pulses", hs_n, 12);
        check("hs_idle_after", {busy, vid_hs}, 2'b01);

        // Async reset between edges during RUN
        glb_ctrl = 32'h0; tick();
        glb_ctrl = 32'h1;
        wait_fs();
        for (int i = 0; i < 5; i++) tick();
        check("arst_pre_run", {busy, vid_hs, vid_x}, {1'b1, 1'b1, 12'd5});
        #2 hrst_n = 0;
        #1;
        check("arst_outputs", {busy, vid_de, vid_hs, vid_vs, frame_start, frame_done, vid_x, vid_y, frame_cnt}, 0);
        #1 hrst_n = 1;
        tick();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
